// File: rtl/fasttwosum_seq_ctrl.sv
// Sequencer for one fasttwosum_step: streams a job of len_i elements through the step,
// holding step inputs stable across its latency, and returns the final sum/error pair.
module fasttwosum_seq_ctrl #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int STEP_LAT     = 7,
  parameter int CNT_WIDTH    = 8,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   len_i,
  output logic                   busy_o,
  input  logic                   elem_valid_i,
  input  logic [BIT_WIDTH_I-1:0] elem_i,
  output logic                   elem_ready_o,
  output logic [BIT_WIDTH_I-1:0] step_elem_o,
  output logic [BIT_WIDTH_I-1:0] step_sum_o,
  output logic [BIT_WIDTH_I-1:0] step_error_o,
  input  logic [BIT_WIDTH_I-1:0] step_sum_i,
  input  logic [BIT_WIDTH_I-1:0] step_error_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [BIT_WIDTH_I-1:0] res_sum_o,
  output logic [BIT_WIDTH_I-1:0] res_error_o,
  output logic [CNT_WIDTH-1:0]   count_o
);

  localparam int HOLD_W = (STEP_LAT < 1) ? 1 : $clog2(STEP_LAT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                 state_r;
  state_e                 state_s;
  logic [CNT_WIDTH-1:0]   len_r;
  logic [CNT_WIDTH-1:0]   count_r;
  logic [CNT_WIDTH-1:0]   count_inc_s;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic                   step_done_s;
  logic                   len_zero_s;
  logic [BIT_WIDTH_I-1:0] acc_sum_r;
  logic [BIT_WIDTH_I-1:0] acc_err_r;
  logic [BIT_WIDTH_I-1:0] step_elem_r;
  logic [BIT_WIDTH_I-1:0] step_sum_r;
  logic [BIT_WIDTH_I-1:0] step_err_r;

  assign count_inc_s = count_r + CNT_WIDTH'(1);
  // The step result is sampled only in the last HOLD cycle, c0+STEP_LAT.
  assign step_done_s = (state_r == HOLD) && (hold_cnt_r == HOLD_LAST);
  assign len_zero_s  = (len_i == {CNT_WIDTH{1'b0}});

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; clear_i overrides every other event
  always_comb begin
    state_s = state_r;
    if (clear_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_s = len_zero_s ? DONE : WAIT;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT: begin
          if (elem_valid_i) begin
            state_s = HOLD;
          end else begin
            state_s = WAIT;
          end
        end
        HOLD: begin
          if (step_done_s) begin
            state_s = (count_inc_s == len_r) ? DONE : WAIT;
          end else begin
            state_s = HOLD;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Handshake/status outputs decoded from state only
  always_comb begin
    busy_o       = 1'b0;
    elem_ready_o = 1'b0;
    res_valid_o  = 1'b0;
    case (state_r)
      IDLE:    busy_o = 1'b0;
      WAIT:    begin busy_o = 1'b1; elem_ready_o = 1'b1; end
      HOLD:    busy_o = 1'b1;
      DONE:    begin busy_o = 1'b1; res_valid_o = 1'b1; end
      default: busy_o = 1'b0;
    endcase
  end

  // Job length, accumulator, element count, hold counter and frozen step operands
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_r       <= {CNT_WIDTH{1'b0}};
      count_r     <= {CNT_WIDTH{1'b0}};
      hold_cnt_r  <= {HOLD_W{1'b0}};
      acc_sum_r   <= {BIT_WIDTH_I{1'b0}};
      acc_err_r   <= {BIT_WIDTH_I{1'b0}};
      step_elem_r <= {BIT_WIDTH_I{1'b0}};
      step_sum_r  <= {BIT_WIDTH_I{1'b0}};
      step_err_r  <= {BIT_WIDTH_I{1'b0}};
    end else if (clear_i) begin
      // Step operands keep their last value so the abandoned step sees no glitch.
      count_r    <= {CNT_WIDTH{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            len_r     <= len_i;
            count_r   <= {CNT_WIDTH{1'b0}};
            acc_sum_r <= {BIT_WIDTH_I{1'b0}};
            acc_err_r <= {BIT_WIDTH_I{1'b0}};
          end
        end
        WAIT: begin
          if (elem_valid_i) begin
            step_elem_r <= elem_i;
            step_sum_r  <= acc_sum_r;
            step_err_r  <= acc_err_r;
            hold_cnt_r  <= {HOLD_W{1'b0}};
          end
        end
        HOLD: begin
          if (step_done_s) begin
            acc_sum_r <= step_sum_i;
            acc_err_r <= step_error_i;
            count_r   <= count_inc_s;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        DONE: begin
          acc_sum_r <= acc_sum_r;
        end
        default: begin
          count_r <= {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign step_elem_o  = step_elem_r;
  assign step_sum_o   = step_sum_r;
  assign step_error_o = step_err_r;
  assign res_sum_o    = acc_sum_r;
  assign res_error_o  = acc_err_r;
  assign count_o      = count_r;

endmodule

// File: tb/tb_fasttwosum_seq_ctrl.sv
// Bench for fasttwosum_seq_ctrl with a stand-in step: an 8-bit modular adder whose carries
// accumulate into the error word, so a job's result is (total mod 256, total div 256).
module tb_fasttwosum_seq_ctrl;
  localparam int LAT = 7;
  localparam int CW  = 8;
  localparam int BW  = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i, start_i, elem_valid_i, res_ready_i;
  logic [CW-1:0] len_i;
  logic [BW-1:0] elem_i;
  logic          busy_o, elem_ready_o, res_valid_o;
  logic [BW-1:0] step_elem_o, step_sum_o, step_error_o, step_sum_i, step_error_i;
  logic [BW-1:0] res_sum_o, res_error_o;
  logic [CW-1:0] count_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] elems [$];

  fasttwosum_seq_ctrl #(
    .EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .STEP_LAT(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .elem_valid_i(elem_valid_i), .elem_i(elem_i), .elem_ready_o(elem_ready_o),
    .step_elem_o(step_elem_o), .step_sum_o(step_sum_o), .step_error_o(step_error_o),
    .step_sum_i(step_sum_i), .step_error_i(step_error_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_sum_o(res_sum_o), .res_error_o(res_error_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Step stand-in: sum/carry read at entry, error word read again at the output stage.
  logic [BW-1:0] pipe_sum [LAT];
  logic          pipe_c   [LAT];
  always @(posedge clk_i) begin
    pipe_sum[0] <= step_sum_o + step_elem_o;
    pipe_c[0]   <= ({1'b0, step_sum_o} + {1'b0, step_elem_o}) > 9'd255;
    for (int k = 1; k < LAT; k++) begin
      pipe_sum[k] <= pipe_sum[k-1];
      pipe_c[k]   <= pipe_c[k-1];
    end
  end
  assign step_sum_i   = pipe_sum[LAT-1];
  assign step_error_i = step_error_o + {7'd0, pipe_c[LAT-1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step operands must not move between consecutive HOLD cycles.
  logic          hold_prev = 1'b0;
  logic [BW-1:0] p_e, p_s, p_r;
  always @(negedge clk_i) begin
    logic in_hold;
    in_hold = rst_ni && busy_o && !elem_ready_o && !res_valid_o;
    if (in_hold && hold_prev)
      chk("hold_stable", {8'd0, step_elem_o, step_sum_o, step_error_o}, {8'd0, p_e, p_s, p_r});
    hold_prev = in_hold;
    p_e = step_elem_o;
    p_s = step_sum_o;
    p_r = step_error_o;
  end

  task automatic run_job(input int len, input int gap, input int stall, input bit noise,
                         input bit chk_rate);
    int idx, gcnt, cyc, s, stable;
    bit v, rdy, prev_rdy;
    logic [7:0] es, ee;
    int rises [$];
    idx = 0; gcnt = 0; cyc = 0; s = 0; stable = 0; prev_rdy = 1'b0;
    for (int i = 0; i < len; i++) s += int'(elems[i]);
    es = s[7:0];
    ee = s[15:8];
    start_i = 1'b1; len_i = len[7:0];
    @(posedge clk_i); #1;
    start_i = noise;
    len_i   = noise ? 8'd9 : 8'd0;
    chk("busy_after_start", busy_o, 1);
    if (len == 0) begin
      chk("zero_len_valid", res_valid_o, 1);
      chk("zero_len_no_ready", elem_ready_o, 0);
    end
    while (!res_valid_o && cyc < 2000) begin
      v = (idx < len) && (gcnt == 0);
      elem_valid_i = v;
      elem_i = v ? elems[idx] : 8'h00;
      rdy = elem_ready_o;
      if (rdy && !prev_rdy) rises.push_back(cyc);
      prev_rdy = rdy;
      @(posedge clk_i); #1;
      if (v && rdy) begin
        idx++;
        gcnt = gap;
      end else if (gcnt > 0) begin
        gcnt--;
      end
      cyc++;
    end
    elem_valid_i = 1'b0;
    chk("job_done", res_valid_o, 1);
    chk("elems_taken", idx, len);
    if (chk_rate) begin
      chk("ready_pulses", rises.size(), len);
      for (int k = 1; k < rises.size(); k++)
        chk("ready_period", rises[k] - rises[k-1], LAT + 2);
    end
    for (int k = 0; k < stall; k++) begin
      if (res_valid_o && res_sum_o == es && res_error_o == ee) stable++;
      @(posedge clk_i); #1;
    end
    chk("stall_stable", stable, stall);
    res_ready_i = 1'b1;
    chk("res_sum", res_sum_o, es);
    chk("res_error", res_error_o, ee);
    chk("count", count_o, len);
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    start_i = 1'b0;
    chk("valid_drop", res_valid_o, 0);
    chk("idle_after", busy_o, 0);
  endtask

  initial begin
    int n, cyc, len;
    bit rdy;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; elem_valid_i = 1'b0;
    res_ready_i = 1'b0; len_i = 8'd0; elem_i = 8'd0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_flags", {busy_o, elem_ready_o, res_valid_o}, 0);
    chk("rst_count", count_o, 0);
    chk("rst_res", {res_sum_o, res_error_o}, 0);
    chk("rst_step", {step_elem_o, step_sum_o, step_error_o}, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    elems = {8'd1, 8'd2, 8'd3, 8'd4};
    run_job(4, 0, 0, 1'b0, 1'b1);
    elems.delete();
    run_job(0, 0, 0, 1'b0, 1'b0);
    elems = {8'd200, 8'd150};
    run_job(2, 0, 5, 1'b0, 1'b0);
    elems = {8'd10, 8'd20, 8'd30};
    run_job(3, 4, 1, 1'b0, 1'b0);

    // Abort in the third HOLD cycle of element 2.
    elems = {8'd7, 8'd9, 8'd11};
    start_i = 1'b1; len_i = 8'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 100) begin
      elem_valid_i = 1'b1; elem_i = elems[n]; rdy = elem_ready_o;
      @(posedge clk_i); #1;
      if (rdy) n++;
      cyc++;
    end
    elem_valid_i = 1'b0;
    chk("clear_setup", n, 2);
    repeat (2) begin @(posedge clk_i); #1; end
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    chk("clear_idle", busy_o, 0);
    chk("clear_count", count_o, 0);
    chk("clear_valid", res_valid_o, 0);
    chk("clear_step_elem", step_elem_o, 9);
    chk("clear_step_sum", step_sum_o, 7);
    repeat (10) begin @(posedge clk_i); #1; end
    chk("late_result_ignored", {busy_o, count_o}, 0);
    elems = {8'd5};
    run_job(1, 0, 0, 1'b0, 1'b0);

    // Start pulses in WAIT/HOLD/DONE and at acceptance are ignored.
    elems = {8'd40, 8'd2};
    run_job(2, 0, 2, 1'b1, 1'b0);

    // Reset mid-job clears everything without a clock edge.
    elems = {8'd3, 8'd4, 8'd5};
    start_i = 1'b1; len_i = 8'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0; elem_valid_i = 1'b1; elem_i = 8'd3;
    @(posedge clk_i); #1;
    elem_valid_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    #1 rst_ni = 1'b0;
    #1;
    chk("amid_flags", {busy_o, elem_ready_o, res_valid_o}, 0);
    chk("amid_step", {step_elem_o, step_sum_o, step_error_o}, 0);
    chk("amid_res", {count_o, res_sum_o, res_error_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    elems = {8'd66};
    run_job(1, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 6);
      elems.delete();
      for (int i = 0; i < len; i++) elems.push_back(8'($urandom_range(0, 255)));
      run_job(len, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
